// File: rtl/fire_pkg.sv
// Shared types and defaults for the launcher fire scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fire_pkg;

    localparam int unsigned CNT_W  = 32;
    localparam int unsigned SHOT_W = 16;

    localparam int unsigned DEF_FRAME_CYCLES    = 1000000;
    localparam int unsigned DEF_IDLE_WIDTH      = 75000;
    localparam int unsigned DEF_FWD_WIDTH       = 80000;
    localparam int unsigned DEF_REV_WIDTH       = 50000;
    localparam int unsigned DEF_SPINUP_CYCLES   = 12500000;
    localparam int unsigned DEF_FIRE_CYCLES     = 25000000;
    localparam int unsigned DEF_RETRACT_CYCLES  = 12500000;
    localparam int unsigned DEF_COOLDOWN_CYCLES = 25000000;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SPINUP   = 3'd1,
        ST_FIRE     = 3'd2,
        ST_RETRACT  = 3'd3,
        ST_COOLDOWN = 3'd4
    } state_e;

endpackage

// File: rtl/pwm_frame_gen.sv
// Servo-style PWM: free-running frame, width latched at frame start.
// Latency: signal is registered, one cycle behind the frame counter.
// Backpressure: none; width_in is sampled only when the frame counter is 0.
module pwm_frame_gen
    import fire_pkg::*;
#(
    parameter int unsigned FRAME_CYCLES = DEF_FRAME_CYCLES,
    parameter int unsigned RESET_WIDTH  = DEF_IDLE_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [CNT_W-1:0] width_in,
    output logic             signal
);

    logic [CNT_W-1:0] frame_q, frame_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic             signal_q, signal_d;

    always_comb begin
        frame_d  = (frame_q == CNT_W'(FRAME_CYCLES - 1)) ? '0 : frame_q + 1'b1;
        // Only adopt a new width on a frame boundary so no pulse is cut or stretched.
        width_d  = (frame_q == '0) ? width_in : width_q;
        signal_d = (frame_q < width_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            frame_q  <= '0;
            width_q  <= CNT_W'(RESET_WIDTH);
            signal_q <= 1'b0;
        end else begin
            frame_q  <= frame_d;
            width_q  <= width_d;
            signal_q <= signal_d;
        end
    end

    assign signal = signal_q;

endmodule

// File: rtl/fire_scheduler.sv
// Round-robin fire arbiter and shot sequencer driving the launcher PWM pin.
// Latency: grant one cycle after a sampled req; done on the RETRACT->COOLDOWN edge.
// Backpressure: requests are only sampled in IDLE; others are dropped, not queued.
module fire_scheduler
    import fire_pkg::*;
#(
    parameter int unsigned NREQ            = 2,
    parameter int unsigned FRAME_CYCLES    = DEF_FRAME_CYCLES,
    parameter int unsigned IDLE_WIDTH      = DEF_IDLE_WIDTH,
    parameter int unsigned FWD_WIDTH       = DEF_FWD_WIDTH,
    parameter int unsigned REV_WIDTH       = DEF_REV_WIDTH,
    parameter int unsigned SPINUP_CYCLES   = DEF_SPINUP_CYCLES,
    parameter int unsigned FIRE_CYCLES     = DEF_FIRE_CYCLES,
    parameter int unsigned RETRACT_CYCLES  = DEF_RETRACT_CYCLES,
    parameter int unsigned COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic              abort,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    output logic [2:0]        phase,
    output logic [SHOT_W-1:0] shot_count,
    output logic              signal
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [SHOT_W-1:0] shot_q, shot_d;

    logic              found;
    logic [PW-1:0]     winner;
    logic [CNT_W-1:0]  idx;
    logic [CNT_W-1:0]  target_width;

    // Scan starting at rr_ptr, wrapping, and keep the first requester seen.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = CNT_W'(rr_ptr_q) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req[idx[PW-1:0]]) begin
                found  = 1'b1;
                winner = idx[PW-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        done_d   = '0;
        shot_d   = shot_q;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (found) begin
                    state_d  = ST_SPINUP;
                    grant_d  = NREQ'(1) << winner;
                    rr_ptr_d = (winner == PW'(NREQ - 1)) ? '0 : winner + 1'b1;
                end
            end
            ST_SPINUP: begin
                if (abort) begin
                    state_d = ST_RETRACT;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(SPINUP_CYCLES - 1)) begin
                    state_d = ST_FIRE;
                    cnt_d   = '0;
                end
            end
            ST_FIRE: begin
                // Abort wins over a natural end so an aborted shot is never counted.
                if (abort) begin
                    state_d = ST_RETRACT;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(FIRE_CYCLES - 1)) begin
                    state_d = ST_RETRACT;
                    cnt_d   = '0;
                    shot_d  = (shot_q == '1) ? shot_q : shot_q + 1'b1;
                end
            end
            ST_RETRACT: begin
                if (cnt_q == CNT_W'(RETRACT_CYCLES - 1)) begin
                    state_d = ST_COOLDOWN;
                    cnt_d   = '0;
                    done_d  = grant_q;
                    grant_d = '0;
                end
            end
            ST_COOLDOWN: begin
                if (cnt_q == CNT_W'(COOLDOWN_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            shot_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            shot_q   <= shot_d;
        end
    end

    always_comb begin
        target_width = CNT_W'(IDLE_WIDTH);
        unique case (state_q)
            ST_SPINUP, ST_RETRACT: target_width = CNT_W'(FWD_WIDTH);
            ST_FIRE:               target_width = CNT_W'(REV_WIDTH);
            default:               target_width = CNT_W'(IDLE_WIDTH);
        endcase
    end

    pwm_frame_gen #(
        .FRAME_CYCLES (FRAME_CYCLES),
        .RESET_WIDTH  (IDLE_WIDTH)
    ) u_pwm (
        .clock    (clock),
        .reset    (reset),
        .width_in (target_width),
        .signal   (signal)
    );

    assign grant      = grant_q;
    assign done       = done_q;
    assign busy       = (state_q != ST_IDLE);
    assign phase      = state_q;
    assign shot_count = shot_q;

endmodule

// File: doc/fire_scheduler.md
Name: fire_scheduler

Overview:
- Arbitrates fire requests from NREQ requesters (processor command, manual button, …) onto the single launcher ESC/servo channel.
- Sequences each granted shot through spin-up, fire, retract and cooldown phases. Each phase has its own pulse width and duration.
- Generates the 50 Hz servo-style PWM frame itself, so its `signal` output drives the launcher pin directly.

Parameters:
- NREQ, 2, number of requesters (2..8).
- FRAME_CYCLES, 1000000, PWM frame period in clocks (20 ms at 50 MHz).
- IDLE_WIDTH, 75000, neutral pulse width in clocks (1.5 ms).
- FWD_WIDTH, 80000, pulse width during SPINUP and RETRACT.
- REV_WIDTH, 50000, pulse width during FIRE.
- SPINUP_CYCLES, 12500000, SPINUP duration.
- FIRE_CYCLES, 25000000, FIRE duration.
- RETRACT_CYCLES, 12500000, RETRACT duration.
- COOLDOWN_CYCLES, 25000000, minimum idle time between shots.

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- req  in  NREQ  level fire requests, one bit per requester.
- abort  in  1  cut the shot short; go to RETRACT.
- grant  out  NREQ  one-hot, held from SPINUP entry through the end of RETRACT.
- done  out  NREQ  one-cycle pulse to the granted requester when RETRACT completes.
- busy  out  1  high in any state other than IDLE.
- phase  out  3  current state encoding.
- shot_count  out  16  completed shots; saturates at 16'hFFFF.
- signal  out  1  PWM output.

Behaviour:
- States: IDLE(0), SPINUP(1), FIRE(2), RETRACT(3), COOLDOWN(4). Single 32-bit phase counter, cleared on every state entry.
- IDLE:
  - If any req bit is high, pick the first set bit at or after rr_ptr (wrapping).
  - Next cycle: state=SPINUP, grant=onehot(winner), rr_ptr=(winner+1) mod NREQ.
  - Requests are sampled only in IDLE; req in any other state is ignored, not queued.
- SPINUP → FIRE when counter == SPINUP_CYCLES-1.
- FIRE → RETRACT when counter == FIRE_CYCLES-1. shot_count increments on this transition.
- RETRACT → COOLDOWN when counter == RETRACT_CYCLES-1. On that same edge: grant clears and done pulses for the granted bit.
- COOLDOWN → IDLE when counter == COOLDOWN_CYCLES-1.
- abort:
  - In SPINUP or FIRE: next state is RETRACT and the counter clears. shot_count is not incremented. done still pulses at the end of RETRACT.
  - In IDLE, RETRACT or COOLDOWN: ignored.
  - abort has priority over a simultaneous natural end of FIRE, so that shot is not counted.
- Requester protocol: drop req after done. A req still high re-arbitrates after COOLDOWN, and round-robin gives any other pending requester priority.
- Target width per state: IDLE and COOLDOWN use IDLE_WIDTH; SPINUP and RETRACT use FWD_WIDTH; FIRE uses REV_WIDTH.
- PWM frame:
  - frame_cnt is free-running over 0..FRAME_CYCLES-1 and independent of the state machine.
  - width_q loads the target width only when frame_cnt==0, so no truncated or stretched pulses occur mid-frame.
  - signal is registered: signal <= (frame_cnt < width_q), giving one cycle of latency.
- Reset values:
  - state=IDLE, all counters 0, rr_ptr=0, width_q=IDLE_WIDTH.
  - grant=0, done=0, busy=0, phase=0, shot_count=0, signal=0.
- Reset mid-shot returns to IDLE immediately. No done pulse is issued for the interrupted shot.
- Widths: all counters are 32-bit unsigned. Widths must be less than FRAME_CYCLES, and all durations must be at least 1.

Decomposition:
- fire_pkg holds:
  - the state enum (3-bit) with the encodings above;
  - counter width constant (32);
  - shot_count width (16);
  - default width and duration constants.
- Sub-module pwm_frame_gen:
  - ports: clock, reset, width_in[31:0], signal;
  - parameter: FRAME_CYCLES;
  - contents: frame counter, frame-start width latch, registered compare.
- fire_scheduler instantiates one pwm_frame_gen and contains the arbiter and state machine.

Test Plan:
All scenarios use scaled parameters: NREQ=2, FRAME=100, IDLE=30, FWD=40, REV=10, SPINUP=200, FIRE=400, RETRACT=200, COOLDOWN=100.
- Idle after reset → signal high 30 of every 100 cycles; busy=0; grant=0.
- req=01 for 1 cycle → next cycle grant=01, phase=1; phase=2 after 200 cycles, 3 after 400 more, 4 after 200 more. done[0] pulses once at the 3→4 edge, then phase=0 after 100 more. shot_count=1. High time per frame: 40 in SPINUP, 10 in FIRE, 40 in RETRACT.
- req=11 held continuously → grants alternate 01,10,01 across three shots. Each done pulse goes to the matching bit.
- abort at SPINUP cycle 50 → next cycle phase=3; RETRACT lasts 200 cycles; done pulses; shot_count unchanged.
- State changes mid-frame (frame_cnt=5) → the width change appears only at the next frame_cnt==0. No pulse in the transition frame differs from 30 or 40 high cycles.
- reset asserted during FIRE → next cycle phase=0, grant=0, shot_count=0, signal=0, with no done pulse. req=10 afterwards grants bit 1 (rr_ptr reset to 0, bit 0 not requesting).
